// File: rtl/tick_pkg.sv
// Shared constants and divider helpers for tick_digit_counter and count_digit.
package tick_pkg;
    localparam int DIGIT_W   = 4;
    localparam int RADIX_DEC = 10;
    localparam int RADIX_HEX = 16;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Prescaler counts 0..DIV-1, so clog2(DIV) bits suffice; floor of 1 bit.
    function automatic int calc_pre_w(input int clk_hz, input int tick_hz);
        int div;
        div = calc_div(clk_hz, tick_hz);
        return (div < 2) ? 1 : $clog2(div);
    endfunction
endpackage

// File: rtl/count_digit.sv
// One 4-bit counter digit of modulus RADIX with clamped load and
// combinational carry/borrow out.
module count_digit
    import tick_pkg::*;
#(
    parameter int RADIX = RADIX_HEX
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               dir,
    input  logic               cin,
    input  logic               clear,
    input  logic               load,
    input  logic [DIGIT_W-1:0] ld_val,
    output logic [DIGIT_W-1:0] q,
    output logic               cout
);
    localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(RADIX - 1);

    logic               at_limit;
    logic [DIGIT_W-1:0] ld_clamp;

    // Limit is the value that rolls over in the current direction.
    assign at_limit = dir ? (q == MAX_D) : (q == '0);
    assign cout     = at_limit & cin;
    assign ld_clamp = (ld_val > MAX_D) ? MAX_D : ld_val;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= ld_clamp;
        end else if (en && cin) begin
            if (dir) begin
                q <= (q == MAX_D) ? '0 : q + 1'b1;
            end else begin
                q <= (q == '0) ? MAX_D : q - 1'b1;
            end
        end
    end
endmodule

// File: rtl/tick_digit_counter.sv
// Prescaled multi-digit up/down counter (radix 10 or 16) with clear and load.
// Define TICK_DIGIT_COUNTER_SAT_EN to saturate at the limits instead of wrapping.
module tick_digit_counter
    import tick_pkg::*;
#(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 1,
    parameter int DIGITS  = 4,
    parameter int RADIX   = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        run,
    input  logic                        dir,
    input  logic                        clear,
    input  logic                        load,
    input  logic [DIGIT_W*DIGITS-1:0]   load_val,
    output logic [DIGIT_W*DIGITS-1:0]   values,
    output logic                        tick_out,
    output logic                        carry,
    output logic                        running
);
    localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
    localparam int PRE_W = calc_pre_w(CLK_HZ, TICK_HZ);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    if (RADIX != RADIX_DEC && RADIX != RADIX_HEX) begin : g_bad_radix
        $error("tick_digit_counter: RADIX must be 10 or 16");
    end
    if (DIV < 2) begin : g_bad_div
        $error("tick_digit_counter: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("tick_digit_counter: DIGITS must be in 1..8");
    end

    logic [PRE_W-1:0] pre;
    logic             step;
    logic             wrap;
    logic             dig_en;
    logic [DIGITS:0]  chain;

    // run is sampled on the same edge as the terminal count, so a falling
    // run at DIV-1 suppresses the step; clear/load also swallow it.
    assign step     = run & (pre == PRE_LAST) & ~clear & ~load;
    assign chain[0] = 1'b1;
    assign wrap     = chain[DIGITS];

`ifdef TICK_DIGIT_COUNTER_SAT_EN
    assign dig_en = step & ~wrap;
`else
    assign dig_en = step;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
        end else if (clear || load) begin
            pre <= '0;
        end else if (run) begin
            pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        count_digit #(
            .RADIX (RADIX)
        ) u_digit (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (dig_en),
            .dir     (dir),
            .cin     (chain[i]),
            .clear   (clear),
            .load    (load),
            .ld_val  (load_val[i*DIGIT_W +: DIGIT_W]),
            .q       (values[i*DIGIT_W +: DIGIT_W]),
            .cout    (chain[i+1])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_out <= 1'b0;
            carry    <= 1'b0;
            running  <= 1'b0;
        end else begin
            tick_out <= step;
            carry    <= step & wrap;
            running  <= run;
        end
    end
endmodule

// File: tb/tb_tick_digit_counter.sv
// Bench for tick_digit_counter: hex and decimal 2-digit instances, DIV=10,
// checked every cycle against an integer-count model plus directed literals.
module tb_tick_digit_counter;
    localparam int DIV = 10;
`ifdef TICK_DIGIT_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        int   cnt;
        int   pre;
        logic tick;
        logic carry;
    } mstate_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run, dir, clear, load;
    logic [7:0] load_val;
    logic [7:0] vh, vd;
    logic       th, ch, rh, td, cd, rd;

    int errors = 0;
    int checks = 0;

    mstate_t mh, md;
    logic    m_run;

    always #5 clk = ~clk;

    tick_digit_counter #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .RADIX(16)) u_hex (
        .clk(clk), .reset_n(reset_n), .run(run), .dir(dir), .clear(clear),
        .load(load), .load_val(load_val), .values(vh), .tick_out(th),
        .carry(ch), .running(rh)
    );

    tick_digit_counter #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .RADIX(10)) u_dec (
        .clk(clk), .reset_n(reset_n), .run(run), .dir(dir), .clear(clear),
        .load(load), .load_val(load_val), .values(vd), .tick_out(td),
        .carry(cd), .running(rd)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_load(input int radix, input logic [7:0] lv);
        int d0, d1;
        d0 = int'(lv[3:0]);
        d1 = int'(lv[7:4]);
        if (d0 >= radix) d0 = radix - 1;
        if (d1 >= radix) d1 = radix - 1;
        return d1 * radix + d0;
    endfunction

    function automatic logic [7:0] to_vals(input int radix, input int cnt);
        logic [3:0] d0, d1;
        d0 = 4'(cnt % radix);
        d1 = 4'((cnt / radix) % radix);
        return {d1, d0};
    endfunction

    // Count held as a plain integer in 0..radix^2-1.
    function automatic mstate_t model_next(input int radix, input mstate_t s,
                                           input logic r, input logic d,
                                           input logic clr, input logic ld,
                                           input logic [7:0] lv);
        mstate_t n;
        int full;
        full    = radix * radix;
        n       = s;
        n.tick  = 1'b0;
        n.carry = 1'b0;
        if (clr) begin
            n.cnt = 0;
            n.pre = 0;
        end else if (ld) begin
            n.cnt = clamp_load(radix, lv);
            n.pre = 0;
        end else if (r) begin
            if (s.pre == DIV - 1) begin
                n.pre  = 0;
                n.tick = 1'b1;
                if (d) begin
                    if (s.cnt == full - 1) begin
                        n.carry = 1'b1;
                        n.cnt   = SAT ? s.cnt : 0;
                    end else begin
                        n.cnt = s.cnt + 1;
                    end
                end else begin
                    if (s.cnt == 0) begin
                        n.carry = 1'b1;
                        n.cnt   = SAT ? 0 : full - 1;
                    end else begin
                        n.cnt = s.cnt - 1;
                    end
                end
            end else begin
                n.pre = s.pre + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mh    <= '0;
            md    <= '0;
            m_run <= 1'b0;
        end else begin
            mh    <= model_next(16, mh, run, dir, clear, load, load_val);
            md    <= model_next(10, md, run, dir, clear, load, load_val);
            m_run <= run;
        end
    end

    always begin
        @(posedge clk);
        #2;
        check("hex.values",  32'(vh), 32'(to_vals(16, mh.cnt)));
        check("hex.tick",    32'(th), 32'(mh.tick));
        check("hex.carry",   32'(ch), 32'(mh.carry));
        check("hex.running", 32'(rh), 32'(m_run));
        check("dec.values",  32'(vd), 32'(to_vals(10, md.cnt)));
        check("dec.tick",    32'(td), 32'(md.tick));
        check("dec.carry",   32'(cd), 32'(md.carry));
        check("dec.running", 32'(rd), 32'(m_run));
    end

    // Returns at the negedge where the selected tick_out is seen high.
    task automatic wait_tick(input bit use_dec, input int bound, output int cycles);
        logic seen;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < bound) begin
            @(negedge clk);
            cycles++;
            seen = use_dec ? td : th;
        end
        if (!seen) check("tick_timeout", 0, 1);
    endtask

    initial begin
        int cyc;
        int r;
        reset_n  = 1'b0;
        run      = 1'b0;
        dir      = 1'b1;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;
        repeat (3) @(negedge clk);
        check("reset.values",  32'(vh), 0);
        check("reset.tick",    32'(th), 0);
        check("reset.running", 32'(rh), 0);

        reset_n = 1'b1;
        run     = 1'b1;
        wait_tick(1'b0, 30, cyc);
        check("first_tick_delay", cyc, 10);
        check("first_step", 32'(vh), 32'h01);
        wait_tick(1'b0, 30, cyc);
        check("second_tick_delay", cyc, 10);
        check("second_step", 32'(vh), 32'h02);

        load = 1'b1; load_val = 8'h99;
        @(negedge clk);
        load = 1'b0;
        check("dec.load99", 32'(vd), 32'h99);
        wait_tick(1'b1, 30, cyc);
        check("dec.wrap_delay", cyc, 10);
        check("dec.wrap_up", 32'(vd), 32'h00);
        check("dec.carry_up", 32'(cd), 1);
        @(negedge clk);
        check("dec.carry_one_cycle", 32'(cd), 0);

        load = 1'b1; load_val = 8'h00; dir = 1'b0;
        @(negedge clk);
        load = 1'b0;
        wait_tick(1'b1, 30, cyc);
        check("dec.wrap_down", 32'(vd), 32'h99);
        check("dec.borrow", 32'(cd), 1);
        check("hex.wrap_down", 32'(vh), 32'hFF);
        check("hex.borrow", 32'(ch), 1);

        // load at a terminal-count edge beats the step
        repeat (9) @(negedge clk);
        load = 1'b1; load_val = 8'hAF;
        @(negedge clk);
        load = 1'b0;
        check("dec.clamp", 32'(vd), 32'h99);
        check("dec.load_no_tick", 32'(td), 0);
        check("hex.load_af", 32'(vh), 32'hAF);
        check("hex.load_no_tick", 32'(th), 0);

        repeat (5) @(negedge clk);
        run = 1'b0;
        repeat (20) @(negedge clk);
        check("hold.values", 32'(vh), 32'hAF);
        run = 1'b1;
        wait_tick(1'b0, 30, cyc);
        check("resume_delay", cyc, 5);
        check("resume_step", 32'(vh), 32'hAE);

        repeat (9) @(negedge clk);
        clear = 1'b1; load = 1'b1; load_val = 8'h55;
        @(negedge clk);
        clear = 1'b0; load = 1'b0; dir = 1'b1;
        check("clr_ld.values", 32'(vh), 0);
        check("clr_ld.tick", 32'(th), 0);
        check("clr_ld.carry", 32'(ch), 0);
        wait_tick(1'b0, 30, cyc);
        check("clr_ld.pre_zero", cyc, 10);

        repeat (9) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        check("run_fall.no_tick", 32'(th), 0);
        run = 1'b1;
        wait_tick(1'b0, 30, cyc);
        check("run_fall.resume", cyc, 1);
        check("run_fall.step", 32'(vh), 32'h02);

        load = 1'b1; load_val = 8'hFF; dir = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_tick(1'b0, 30, cyc);
        check("limit.hex", 32'(vh), SAT ? 32'hFF : 32'h00);
        check("limit.hex_carry", 32'(ch), 1);
        check("limit.dec", 32'(vd), SAT ? 32'h99 : 32'h00);
        check("limit.dec_carry", 32'(cd), 1);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            r        = int'($urandom_range(0, 999));
            reset_n  = (r >= 3);
            clear    = (r >= 3 && r < 10);
            load     = (r >= 10 && r < 25);
            load_val = 8'($urandom);
            run      = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) dir = ~dir;
        end

        @(negedge clk);
        reset_n = 1'b1; clear = 1'b0; load = 1'b0;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tick_digit_counter.md
Name: tick_digit_counter

Overview:
- Parametrised successor of the fixed 1 Hz prescaler plus 4-bit counter in the lab top level.
- Generates a tick enable at TICK_HZ from the system clock.
- Drives a DIGITS-wide multi-digit counter in RADIX 10 or 16, with up/down, run/hold, synchronous clear and parallel load.
- Its packed output feeds seven_seg values directly; its status feeds MicroBlaze MCS GPIO inputs.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- TICK_HZ, 1, count rate in Hz; DIV = CLK_HZ/TICK_HZ, must be >= 2.
- DIGITS, 4, number of 4-bit digits, range 1..8.
- RADIX, 16, per-digit modulus, only 10 or 16 legal; elaboration error otherwise.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  1 = prescaler and counter advance; 0 = hold.
- dir  in  1  1 = count up, 0 = count down.
- clear  in  1  synchronous clear of counter and prescaler.
- load  in  1  synchronous parallel load.
- load_val  in  4*DIGITS  load value, digit 0 in bits [3:0].
- values  out  4*DIGITS  current count, digit 0 in bits [3:0].
- tick_out  out  1  one-cycle pulse on each count step.
- carry  out  1  one-cycle pulse on full-count wrap.
- running  out  1  registered copy of run.

Behaviour:
- Reset (reset_n low, asynchronous): prescaler=0, values=0, tick_out=0, carry=0, running=0.
- Prescaler: width clog2(DIV).
  - run=1: increments each cycle; at DIV-1 it returns to 0 and a step occurs on that same edge.
  - run=0: prescaler holds its value (pause/resume keeps phase); no steps.
- Step, registered: values change on the step edge; tick_out is high for the following cycle, aligned with the new values.
- Up step: digit 0 increments; a digit at RADIX-1 goes to 0 and carries into the next digit (ripple within one cycle).
- Down step: digit 0 decrements; a digit at 0 goes to RADIX-1 and borrows from the next digit.
- carry: asserted with tick_out when the whole count wraps, either all-max to all-zero (up) or all-zero to all-max (down).
- Priority per edge, highest first: clear > load > step.
  - clear: values=0, prescaler=0, no tick_out, no carry.
  - load: values=load_val, prescaler=0, no tick_out, no carry. Each load_val digit >= RADIX is clamped to RADIX-1.
- dir may change at any cycle; it is sampled on the step edge only.
- Simultaneous run fall and prescaler==DIV-1: the step does not occur, because run is sampled on that edge.
- reset_n asserted mid-operation clears all state immediately; the first step occurs DIV cycles after run=1 with reset_n high.
- running updates one cycle after run.

Optional Feature:
- Macro TICK_DIGIT_COUNTER_SAT_EN.
- Defined:
  - Counter saturates: up at all-(RADIX-1), down at all-zero.
  - A step at the limit leaves values unchanged; tick_out still pulses and carry pulses to flag the overflow attempt.
- Undefined: wrap behaviour as above.

Decomposition:
- Shared package tick_pkg holds:
  - constant DIGIT_W=4;
  - legal radix constants RADIX_DEC=10 and RADIX_HEX=16;
  - a function computing DIV and prescaler width from CLK_HZ/TICK_HZ.
- One natural sub-module, count_digit, instantiated DIGITS times. It holds one 4-bit register and takes inputs en, dir, cin (carry/borrow in), clear, load and ld_val. It outputs q and cout, where cout is combinational (digit at limit AND cin).

Test Plan (CLK_HZ=10, TICK_HZ=1, so DIV=10; DIGITS=2):
- reset_n low then high, run=1, dir=1 with RADIX=16: first tick_out 10 cycles after release; values=0x01, then 0x02 every 10 cycles.
- RADIX=10, load 0x99, run up: next step gives values=0x00 and carry=1 for one cycle; load 0x00 with dir=0 gives 0x99 and carry=1.
- RADIX=10, load_val=0xAF: values=0x99 (clamped); no tick_out in that cycle.
- run=1 for 5 cycles, run=0 for 20 cycles, run=1: step occurs 5 cycles after resume; values unchanged during hold.
- clear and load both high at a step edge: values=0x00, prescaler=0, tick_out=0, carry=0.
- TICK_DIGIT_COUNTER_SAT_EN defined, RADIX=16, values=0xFF, dir=1: step leaves 0xFF, tick_out=1, carry=1. Without the macro, values=0x00.
